// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// stage-4 writeback and a multi-cycle execution unit (valid/ready).
// The pipeline has priority; a wait counter forces one secondary grant (and a
// one-cycle stage-4 stall) after STARVE_LIMIT waiting cycles.
// Optional build macro: WB_ZERO_GUARD_EN -- suppress rf_we for writes to r0.
// Reset rst is asynchronous and active-low.

module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_we,
    input  logic              p_store_pc,
    input  logic [ADDR_W-1:0] p_wa,
    input  logic [DATA_W-1:0] p_wd,
    input  logic [DATA_W-1:0] p_link,
    input  logic              s_valid,
    input  logic [ADDR_W-1:0] s_wa,
    input  logic [DATA_W-1:0] s_wd,
    output logic              s_ready,
    output logic              stall_wb,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              force_grant;
    logic              grant_p;
    logic              grant_s;
    logic              grant_any;
    logic              wr_en;
    logic [ADDR_W-1:0] wa_sel;
    logic [DATA_W-1:0] wd_sel;

    // Grant decision, write-port mux and wait-counter next value.
    always_comb begin
        force_grant  = s_valid && (wait_cnt == LIMIT);
        grant_s      = s_valid && (force_grant || !p_we);
        grant_p      = p_we && !force_grant;
        grant_any    = grant_p || grant_s;
        wa_sel       = grant_s ? s_wa : p_wa;
        wd_sel       = grant_s ? s_wd : (p_store_pc ? p_link : p_wd);
        wait_cnt_nxt = wait_cnt;
        if (!s_valid || grant_s) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
`ifdef WB_ZERO_GUARD_EN
        wr_en = grant_any && (wa_sel != '0);
`else
        wr_en = grant_any;
`endif
    end

    // Handshake and stall outputs are held low while reset is asserted.
    always_comb begin
        s_ready  = rst && grant_s;
        stall_wb = rst && force_grant && p_we;
    end

    // Registered write port and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            rf_we    <= wr_en;
            if (grant_any) begin
                rf_wa <= wa_sel;
                rf_wd <= wd_sel;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors push the expected
// register-file write into a queue; a monitor pops one entry per clock.
`timescale 1ns/1ps

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_we, p_store_pc;
    logic [4:0]  p_wa;
    logic [15:0] p_wd, p_link;
    logic        s_valid;
    logic [4:0]  s_wa;
    logic [15:0] s_wd;
    logic        s_ready, stall_wb;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [15:0] rf_wd;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

`ifdef WB_ZERO_GUARD_EN
    localparam logic ZWE = 1'b0;
`else
    localparam logic ZWE = 1'b1;
`endif

    wb_port_arbiter #(
        .DATA_W(16), .ADDR_W(5), .STARVE_LIMIT(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_store_pc(p_store_pc), .p_wa(p_wa), .p_wd(p_wd), .p_link(p_link),
        .s_valid(s_valid), .s_wa(s_wa), .s_wd(s_wd),
        .s_ready(s_ready), .stall_wb(stall_wb),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational outputs,
    // and queue the write expected after the next rising edge.
    task automatic step(input logic pwe, input logic psp, input logic [4:0] pwa,
                        input logic [15:0] pwd, input logic [15:0] plk,
                        input logic sv, input logic [4:0] swa, input logic [15:0] swd,
                        input logic e_rdy, input logic e_stall,
                        input logic e_we, input logic [4:0] e_wa, input logic [15:0] e_wd);
        exp_t e;
        @(negedge clk);
        p_we = pwe; p_store_pc = psp; p_wa = pwa; p_wd = pwd; p_link = plk;
        s_valid = sv; s_wa = swa; s_wd = swd;
        #1;
        check("s_ready", 32'(s_ready), 32'(e_rdy));
        check("stall_wb", 32'(stall_wb), 32'(e_stall));
        e.we = e_we; e.wa = e_wa; e.wd = e_wd;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered write port after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", 32'(rf_we), 32'(e.we));
                check("rf_wa", 32'(rf_wa), 32'(e.wa));
                check("rf_wd", 32'(rf_wd), 32'(e.wd));
            end
        end
    end

    initial begin
        rst = 1'b0;
        p_we = 1'b1; p_store_pc = 1'b0; p_wa = 5'd7; p_wd = 16'h1234; p_link = 16'h0;
        s_valid = 1'b1; s_wa = 5'd3; s_wd = 16'hBEEF;
        #2;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_stall", 32'(stall_wb), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_wa", 32'(rf_wa), 32'd0);
        check("rst_rf_wd", 32'(rf_wd), 32'd0);

        @(negedge clk);
        p_we = 1'b0; s_valid = 1'b0;
        rst = 1'b1;

        //   pwe psp pwa    pwd       plk       sv   swa    swd       rdy  stl  we   wa     wd
        // Starvation with pipeline priority; first grant after reset is the pipeline.
        step(1, 0, 5'd7,  16'h1234, 16'h0000, 1, 5'd3,  16'hBEEF, 0, 0, 1, 5'd7,  16'h1234);
        step(1, 0, 5'd8,  16'h1111, 16'h0000, 1, 5'd3,  16'hBEEF, 0, 0, 1, 5'd8,  16'h1111);
        step(1, 1, 5'd10, 16'h2222, 16'h00A2, 1, 5'd3,  16'hBEEF, 0, 0, 1, 5'd10, 16'h00A2);
        step(1, 0, 5'd11, 16'h3333, 16'h0000, 1, 5'd3,  16'hBEEF, 1, 1, 1, 5'd3,  16'hBEEF);
        step(1, 0, 5'd11, 16'h3333, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, 1, 5'd11, 16'h3333);
        // Idle holds address/data; secondary-only is accepted at once.
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, 0, 5'd11, 16'h3333);
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 1, 5'd4,  16'hBEEF, 1, 0, 1, 5'd4,  16'hBEEF);
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, 0, 5'd4,  16'hBEEF);
        // Same destination r9: forced secondary first, then the held pipeline write.
        step(1, 0, 5'd1,  16'h0101, 16'h0000, 1, 5'd9,  16'hAAAA, 0, 0, 1, 5'd1,  16'h0101);
        step(1, 0, 5'd2,  16'h0202, 16'h0000, 1, 5'd9,  16'hAAAA, 0, 0, 1, 5'd2,  16'h0202);
        step(1, 0, 5'd5,  16'h0505, 16'h0000, 1, 5'd9,  16'hAAAA, 0, 0, 1, 5'd5,  16'h0505);
        step(1, 0, 5'd9,  16'h5555, 16'h0000, 1, 5'd9,  16'hAAAA, 1, 1, 1, 5'd9,  16'hAAAA);
        // New secondary right after a forced grant: no back-to-back force.
        step(1, 0, 5'd9,  16'h5555, 16'h0000, 1, 5'd6,  16'h6666, 0, 0, 1, 5'd9,  16'h5555);
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 1, 5'd6,  16'h6666, 1, 0, 1, 5'd6,  16'h6666);
        // Second full starvation cycle.
        step(1, 0, 5'd12, 16'h0C0C, 16'h0000, 1, 5'd13, 16'h0D0D, 0, 0, 1, 5'd12, 16'h0C0C);
        step(1, 0, 5'd14, 16'h0E0E, 16'h0000, 1, 5'd13, 16'h0D0D, 0, 0, 1, 5'd14, 16'h0E0E);
        step(1, 0, 5'd15, 16'h0F0F, 16'h0000, 1, 5'd13, 16'h0D0D, 0, 0, 1, 5'd15, 16'h0F0F);
        step(1, 0, 5'd16, 16'h1010, 16'h0000, 1, 5'd13, 16'h0D0D, 1, 1, 1, 5'd13, 16'h0D0D);
        step(1, 0, 5'd16, 16'h1010, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, 1, 5'd16, 16'h1010);
        // Writes to r0 from either side.
        step(1, 0, 5'd0,  16'hABCD, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, ZWE, 5'd0, 16'hABCD);
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 1, 5'd0,  16'h0BAD, 1, 0, ZWE, 5'd0, 16'h0BAD);
        step(0, 0, 5'd0,  16'h0000, 16'h0000, 0, 5'd0,  16'h0000, 0, 0, 0,   5'd0, 16'h0BAD);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during a pending secondary request: not accepted, port cleared.
        @(negedge clk);
        p_we = 1'b1; p_wa = 5'd20; p_wd = 16'h7777;
        s_valid = 1'b1; s_wa = 5'd21; s_wd = 16'h8888;
        rst = 1'b0;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_stall", 32'(stall_wb), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_rf_wd", 32'(rf_wd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
